// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the EX/MEM pipeline
// register and a multi-cycle four-bank data memory.
//
// The controller latches one load or store and reissues it while the memory
// refuses it. It waits for completion, bounded by a timeout, and stalls the
// pipeline until the access finishes. It also produces the one-cycle memory
// dump strobe when HALT reaches MEM.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : an odd request address sends the controller to ERR with no access.
//   undefined : address bit 0 is forced to 0 and the access proceeds normally.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_addr, req_wdata       request address / store data from EX/MEM
//   req_rd, req_wr            load / store request (held while stall=1)
//   halt                      HALT instruction reached MEM
//   mem_addr, mem_wdata       registered address / store data to memory
//   mem_en, mem_wr            memory enable / write strobe (issue cycles)
//   mem_createdump            one-cycle dump strobe after HALT
//   mem_rdata, mem_stall,
//   mem_done                  memory read data, refusal, completion
//   stall                     freeze the pipeline
//   rd_data, rd_valid         registered load result and its valid flag
//   err                       sticky error (unaligned or timeout)
module dmem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        halt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic        mem_createdump,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    output logic        stall,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    // Last count value still tolerated in WAIT; the next miss is a timeout.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        kind_q, kind_d;       // 1 = store, 0 = load
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic        dump_q, dump_d;
    logic        err_q, err_d;
    logic        req_s;
    logic        stall_s;

    assign req_s = req_rd | req_wr;

`ifndef DMEM_ALIGN_CHECK_EN
    // Address bit 0 is discarded when alignment checking is compiled out.
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = req_addr[0];
`endif

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        dump_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A request wins over halt; halt is seen again on return to IDLE.
                if (req_s) begin
`ifdef DMEM_ALIGN_CHECK_EN
                    if (req_addr[0]) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        kind_d  = req_wr;
                        state_d = S_ISSUE;
                    end
`else
                    addr_d  = {req_addr[15:1], 1'b0};
                    wdata_d = req_wdata;
                    kind_d  = req_wr;
                    state_d = S_ISSUE;
`endif
                end else if (halt) begin
                    dump_d  = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_stall) begin
                    state_d = S_ISSUE;
                end else if (mem_done) begin
                    if (!kind_q) begin
                        rd_data_d = mem_rdata;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    if (!kind_q) begin
                        rd_data_d = mem_rdata;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:   state_d = S_IDLE;
            S_ERR:    state_d = S_ERR;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        mem_en_d   = (state_d == S_ISSUE);
        mem_wr_d   = (state_d == S_ISSUE) && kind_d;
        rd_valid_d = (state_d == S_RESP) && !kind_d;
        err_d      = (state_d == S_ERR);
    end

    // Pipeline stall: combinational so a new request freezes EX/MEM at once.
    always_comb begin
        case (state_q)
            S_IDLE:  stall_s = req_s;
            S_RESP:  stall_s = 1'b0;
            default: stall_s = 1'b1;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            kind_q     <= 1'b0;
            cnt_q      <= 4'd0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            dump_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            dump_q     <= dump_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_en         = mem_en_q;
    assign mem_wr         = mem_wr_q;
    assign mem_createdump = dump_q;
    assign stall          = stall_s;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign err            = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: load, stalled store, unaligned address,
// reset mid-access, timeout and halt/dump sequencing.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr, req_wdata;
    logic        req_rd, req_wr, halt;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_en, mem_wr, mem_createdump;
    logic [15:0] mem_rdata;
    logic        mem_stall, mem_done;
    logic        stall;
    logic [15:0] rd_data;
    logic        rd_valid, err;

    int tests = 0;
    int fails = 0;

    dmem_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .req_wr(req_wr), .halt(halt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_createdump(mem_createdump),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check16({tag, "_addr"}, mem_addr, 16'h0000);
        check16({tag, "_wdata"}, mem_wdata, 16'h0000);
        check1({tag, "_en"}, mem_en, 1'b0);
        check1({tag, "_wr"}, mem_wr, 1'b0);
        check1({tag, "_dump"}, mem_createdump, 1'b0);
        check1({tag, "_stall"}, stall, 1'b0);
        check16({tag, "_rd_data"}, rd_data, 16'h0000);
        check1({tag, "_rd_valid"}, rd_valid, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_addr = 16'h0000; req_wdata = 16'h0000;
        req_rd = 1'b0; req_wr = 1'b0; halt = 1'b0;
        mem_rdata = 16'h0000; mem_stall = 1'b0; mem_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;

        // Aligned load at 0x0010, done three cycles after issue
        req_rd = 1'b1; req_addr = 16'h0010;
        #1;
        check1("ld_c0_stall", stall, 1'b1);
        step();                                         // cycle 1: ISSUE
        check1("ld_c1_en", mem_en, 1'b1);
        check1("ld_c1_wr", mem_wr, 1'b0);
        check16("ld_c1_addr", mem_addr, 16'h0010);
        check1("ld_c1_stall", stall, 1'b1);
        step();                                         // cycle 2: WAIT
        check1("ld_c2_en", mem_en, 1'b0);
        check1("ld_c2_stall", stall, 1'b1);
        step();                                         // cycle 3: WAIT
        check1("ld_c3_en", mem_en, 1'b0);
        check1("ld_c3_stall", stall, 1'b1);
        step();                                         // cycle 4: WAIT, done
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        check1("ld_c4_stall", stall, 1'b1);
        step();                                         // cycle 5: RESP
        mem_done = 1'b0; mem_rdata = 16'h0000;
        check1("ld_resp_stall", stall, 1'b0);
        check1("ld_resp_valid", rd_valid, 1'b1);
        check16("ld_resp_data", rd_data, 16'hBEEF);
        check1("ld_resp_en", mem_en, 1'b0);
        req_rd = 1'b0;
        step();                                         // back in IDLE
        check1("ld_idle_valid", rd_valid, 1'b0);
        check16("ld_idle_hold", rd_data, 16'hBEEF);
        check1("ld_idle_stall", stall, 1'b0);

        // Store 0x1234 to 0x0022, memory refuses the first two issues
        req_wr = 1'b1; req_addr = 16'h0022; req_wdata = 16'h1234;
        #1;
        check1("st_c0_stall", stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            mem_stall = (i < 2) ? 1'b1 : 1'b0;
            mem_done  = (i < 2) ? 1'b0 : 1'b1;
            check1("st_iss_en", mem_en, 1'b1);
            check1("st_iss_wr", mem_wr, 1'b1);
            check16("st_iss_addr", mem_addr, 16'h0022);
            check16("st_iss_wdata", mem_wdata, 16'h1234);
        end
        step();                                         // RESP
        mem_stall = 1'b0; mem_done = 1'b0;
        check1("st_resp_en", mem_en, 1'b0);
        check1("st_resp_valid", rd_valid, 1'b0);
        check1("st_resp_stall", stall, 1'b0);
        check16("st_resp_rd_hold", rd_data, 16'hBEEF);
        req_wr = 1'b0;
        step();

        // Odd address 0x0013
        req_rd = 1'b1; req_addr = 16'h0013;
        step();
`ifdef DMEM_ALIGN_CHECK_EN
        check1("ua_en", mem_en, 1'b0);
        check1("ua_err", err, 1'b1);
        check1("ua_stall", stall, 1'b1);
        req_rd = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
`else
        check1("ua_en", mem_en, 1'b1);
        check16("ua_addr", mem_addr, 16'h0012);
        mem_done = 1'b1; mem_rdata = 16'h5A5A;
        step();
        mem_done = 1'b0;
        check1("ua_resp_valid", rd_valid, 1'b1);
        check16("ua_resp_data", rd_data, 16'h5A5A);
        check1("ua_err", err, 1'b0);
        req_rd = 1'b0;
        step();
`endif

        // Reset asserted while in WAIT
        req_rd = 1'b1; req_addr = 16'h0040;
        step();                                         // ISSUE
        check1("rw_issue_en", mem_en, 1'b1);
        step();                                         // WAIT
        step();                                         // WAIT
        check1("rw_wait_stall", stall, 1'b1);
        rst = 1'b1; req_rd = 1'b0;
        #1;
        check_reset_vals("rw");
        #2;
        rst = 1'b0;
        step();
        req_rd = 1'b1; req_addr = 16'h0050;
        step();                                         // ISSUE, done at once
        check1("rw_re_en", mem_en, 1'b1);
        check16("rw_re_addr", mem_addr, 16'h0050);
        mem_done = 1'b1; mem_rdata = 16'hCAFE;
        step();                                         // RESP
        mem_done = 1'b0;
        check1("rw_re_valid", rd_valid, 1'b1);
        check16("rw_re_data", rd_data, 16'hCAFE);
        check1("rw_re_stall", stall, 1'b0);
        req_rd = 1'b0;
        step();

        // Timeout: load with no mem_done
        req_rd = 1'b1; req_addr = 16'h0060;
        step();                                         // ISSUE
        step();                                         // WAIT entry (w)
        check1("to_w0_err", err, 1'b0);
        for (int i = 1; i < 15; i++) begin
            step();                                     // w+1 .. w+14
            check1("to_wait_err", err, 1'b0);
            check1("to_wait_stall", stall, 1'b1);
        end
        step();                                         // w+15: ERR
        check1("to_err", err, 1'b1);
        check1("to_err_stall", stall, 1'b1);
        check1("to_err_en", mem_en, 1'b0);
        req_rd = 1'b0; mem_done = 1'b1;                 // late done is ignored
        step();
        step();
        mem_done = 1'b0;
        check1("to_hold_err", err, 1'b1);
        check1("to_hold_stall", stall, 1'b1);
        check1("to_hold_valid", rd_valid, 1'b0);
        rst = 1'b1;
        #2;
        check1("to_rst_err", err, 1'b0);
        rst = 1'b0;
        step();

        // Halt in IDLE: one dump pulse, then frozen
        halt = 1'b1;
        #1;
        check1("h_idle_stall", stall, 1'b0);
        step();
        halt = 1'b0;
        check1("h_dump", mem_createdump, 1'b1);
        check1("h_stall", stall, 1'b1);
        check1("h_en", mem_en, 1'b0);
        step();
        check1("h_dump_once", mem_createdump, 1'b0);
        check1("h_stall2", stall, 1'b1);
        req_rd = 1'b1; req_addr = 16'h0070;
        step();
        check1("h_req_en", mem_en, 1'b0);
        step();
        check1("h_req_en2", mem_en, 1'b0);
        check1("h_req_dump", mem_createdump, 1'b0);
        check1("h_req_stall", stall, 1'b1);
        req_rd = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
